// File: rtl/dispatch_queue_n_pkg.sv
// Shared types for the rename -> dispatch -> issue/ROB path.
// The index widths here are the widths the ROB / store-queue types are built with;
// the dispatch module's ROB_AW / SQ_AW parameters must match them.
package dispatch_queue_n_pkg;

    localparam int ROB_IDX_W = 4;
    localparam int SQ_IDX_W  = 4;
    localparam int PHY_AW    = 6;
    localparam int ARCH_AW   = 5;
    localparam int BPU_W     = 4;
    localparam int MAX_WIDTH = 4;

    typedef enum logic [1:0] {
        Inst_Invalid = 2'd0,
        Inst_Wait    = 2'd1,
        Inst_Done    = 2'd2,
        Inst_Except  = 2'd3
    } rob_state_e;

    typedef struct packed {
        logic               rf_we;
        logic [ARCH_AW-1:0] dest;
        logic [7:0]         opcode;
        logic [15:0]        imm;
    } inst_t;

    typedef struct packed {
        logic              valid;
        logic [31:0]       pc;
        inst_t             inst;
        logic              src1_ready;
        logic              src2_ready;
        logic [PHY_AW-1:0] phy_src1;
        logic [PHY_AW-1:0] phy_src2;
        logic [PHY_AW-1:0] phy_dest;
        logic [PHY_AW-1:0] old_dest;
        logic              is_store_op;
        logic              br_taken;
        logic [BPU_W-1:0]  bpu_entry;
    } dispatch_slot_t;

    typedef struct packed {
        logic                 valid;
        logic [31:0]          pc;
        inst_t                inst;
        logic                 src1_ready;
        logic                 src2_ready;
        logic [PHY_AW-1:0]    phy_src1;
        logic [PHY_AW-1:0]    phy_src2;
        logic [PHY_AW-1:0]    phy_dest;
        logic [ROB_IDX_W-1:0] rob_entry_num;
        logic [SQ_IDX_W-1:0]  store_num;
        logic [SQ_IDX_W-1:0]  pre_store;
        logic                 pre_store_ready;
        logic                 is_store_op;
        logic                 br_taken;
        logic [BPU_W-1:0]     bpu_entry;
    } decode_to_issue_bus_t;

    typedef struct packed {
        rob_state_e         state;
        logic [31:0]        pc;
        logic [ARCH_AW-1:0] dest;
        logic [PHY_AW-1:0]  phy_dest;
        logic [PHY_AW-1:0]  old_dest;
        logic               is_store_op;
        logic               exception;
        logic               verify_result;
    } rob_entry_t;

    // Number of set bits among bits[0 .. n-1].
    function automatic logic [2:0] popcount_prefix(input logic [MAX_WIDTH-1:0] bits,
                                                   input logic [2:0] n);
        logic [2:0] cnt;
        cnt = 3'd0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            cnt = cnt + ((3'(i) < n) ? {2'b00, bits[i]} : 3'd0);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/dispatch_queue_n_alloc.sv
// Combinational allocator: how many buffered slots can leave this cycle, and the
// ROB index / store number / previous-store tag each lane gets.
module dispatch_alloc
    import dispatch_queue_n_pkg::*;
#(
    parameter int WIDTH       = 2,
    parameter int ROB_AW      = ROB_IDX_W,
    parameter int SQ_AW       = SQ_IDX_W,
    parameter int IQ_CREDIT_W = 4,
    parameter int CW          = $clog2(WIDTH + 1)
) (
    input  logic                 hold,
    input  logic [CW-1:0]        buf_cnt,
    input  logic [WIDTH-1:0]     is_store,
    input  logic [ROB_AW-1:0]    rob_tail,
    input  logic [ROB_AW:0]      rob_free,
    input  logic [SQ_AW-1:0]     sq_tail,
    input  logic [SQ_AW:0]       sq_free,
    input  logic [IQ_CREDIT_W-1:0] iq_free,
    output logic [CW-1:0]        k,
    output logic [CW-1:0]        store_cnt,
    output logic [ROB_AW-1:0]    rob_idx [WIDTH],
    output logic [SQ_AW-1:0]     store_num [WIDTH],
    output logic [SQ_AW-1:0]     pre_store [WIDTH],
    output logic [WIDTH-1:0]     pre_store_ready
);

    localparam logic [SQ_AW:0] SQ_EMPTY = {1'b1, {SQ_AW{1'b0}}};

    logic [MAX_WIDTH-1:0] store_bits;

    // Widen the per-lane store flags to the helper's fixed width.
    always_comb begin
        store_bits = '0;
        store_bits[WIDTH-1:0] = is_store;
    end

    // Longest in-order prefix that fits ROB, IQ and SQ space; stops at the first misfit.
    always_comb begin
        logic fits;
        fits = 1'b1;
        k    = '0;
        for (int n = 1; n <= WIDTH; n++) begin
            if (fits && !hold && (n <= int'(buf_cnt)) && (n <= int'(rob_free)) &&
                (n <= int'(iq_free)) &&
                (int'(popcount_prefix(store_bits, 3'(n))) <= int'(sq_free))) begin
                k = CW'(n);
            end else begin
                fits = 1'b0;
            end
        end
        store_cnt = CW'(popcount_prefix(store_bits, 3'(k)));
    end

    // Per-lane indices: ROB by lane number, SQ by count of older stores in the group.
    always_comb begin
        logic [2:0] s;
        s = 3'd0;
        for (int i = 0; i < WIDTH; i++) begin
            s                  = popcount_prefix(store_bits, 3'(i));
            rob_idx[i]         = rob_tail + ROB_AW'(i);
            store_num[i]       = sq_tail + SQ_AW'(s);
            pre_store[i]       = sq_tail + SQ_AW'(s) - SQ_AW'(1);
            pre_store_ready[i] = (sq_free == SQ_EMPTY) && (s == 3'd0);
        end
    end

endmodule

// File: rtl/dispatch_queue_n.sv
// Registered dispatch stage: buffers one compacted rename group and dispatches the
// longest in-order prefix that fits downstream space, holding the rest.
module dispatch_queue_n
    import dispatch_queue_n_pkg::*;
#(
    parameter int WIDTH       = 2,
    parameter int ROB_AW      = ROB_IDX_W,
    parameter int SQ_AW       = SQ_IDX_W,
    parameter int IQ_CREDIT_W = 4
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         flush,
    input  logic                         stall,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  dispatch_slot_t               in_slot [WIDTH],
    input  logic [ROB_AW-1:0]            rob_tail,
    input  logic [ROB_AW:0]              rob_free,
    input  logic [SQ_AW-1:0]             sq_tail,
    input  logic [SQ_AW:0]               sq_free,
    input  logic [IQ_CREDIT_W-1:0]       iq_free,
    output decode_to_issue_bus_t         issue_bus [WIDTH],
    output rob_entry_t                   rob_bus [WIDTH],
    output logic [$clog2(WIDTH+1)-1:0]   disp_cnt,
    output logic [$clog2(WIDTH+1)-1:0]   store_cnt
);

    localparam int CW = $clog2(WIDTH + 1);

    dispatch_slot_t       buf_slot   [WIDTH];
    dispatch_slot_t       comp_slot  [WIDTH];
    dispatch_slot_t       shift_slot [WIDTH];
    logic [CW-1:0]        buf_cnt;
    logic [CW-1:0]        comp_cnt;
    logic [CW-1:0]        k;
    logic [WIDTH-1:0]     buf_store;
    logic                 hold;
    logic                 capture;
    logic [ROB_AW-1:0]    rob_idx   [WIDTH];
    logic [SQ_AW-1:0]     store_num [WIDTH];
    logic [SQ_AW-1:0]     pre_store [WIDTH];
    logic [WIDTH-1:0]     pre_store_ready;

    // Reset, flush and stall all block dispatch; handshake completes when the buffer empties this cycle.
    always_comb begin
        hold     = stall || flush || !resetn;
        in_ready = resetn && ((buf_cnt == '0) || (k == buf_cnt)) && !flush;
        capture  = in_valid && in_ready;
        for (int i = 0; i < WIDTH; i++) begin
            buf_store[i] = buf_slot[i].is_store_op;
        end
    end

    dispatch_alloc #(
        .WIDTH       (WIDTH),
        .ROB_AW      (ROB_AW),
        .SQ_AW       (SQ_AW),
        .IQ_CREDIT_W (IQ_CREDIT_W),
        .CW          (CW)
    ) u_alloc (
        .hold            (hold),
        .buf_cnt         (buf_cnt),
        .is_store        (buf_store),
        .rob_tail        (rob_tail),
        .rob_free        (rob_free),
        .sq_tail         (sq_tail),
        .sq_free         (sq_free),
        .iq_free         (iq_free),
        .k               (k),
        .store_cnt       (store_cnt),
        .rob_idx         (rob_idx),
        .store_num       (store_num),
        .pre_store       (pre_store),
        .pre_store_ready (pre_store_ready)
    );

    // Squeeze the holes out of the incoming group, keeping program order.
    always_comb begin
        comp_cnt = '0;
        for (int j = 0; j < WIDTH; j++) begin
            comp_slot[j] = '0;
        end
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                comp_slot[j] = (in_slot[i].valid && (CW'(j) == comp_cnt)) ? in_slot[i] : comp_slot[j];
            end
            comp_cnt = comp_cnt + CW'(in_slot[i].valid);
        end
    end

    // Remainder after a partial dispatch moves down to lane 0.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            shift_slot[i] = '0;
            for (int j = 0; j < WIDTH; j++) begin
                shift_slot[i] = (j == i + int'(k)) ? buf_slot[j] : shift_slot[i];
            end
        end
    end

    // Buffer state: flush/reset empty it, capture replaces it, dispatch drains it.
    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            buf_cnt <= '0;
        end else if (capture) begin
            buf_cnt  <= comp_cnt;
            buf_slot <= comp_slot;
        end else if (k != '0) begin
            buf_cnt  <= buf_cnt - k;
            buf_slot <= shift_slot;
        end else begin
            buf_cnt <= buf_cnt;
        end
    end

    // Drive the dispatched prefix onto the issue and ROB buses; other lanes stay all-zero.
    always_comb begin
        disp_cnt = k;
        for (int i = 0; i < WIDTH; i++) begin
            issue_bus[i] = '0;
            rob_bus[i]   = '0;
            if (CW'(i) < k) begin
                issue_bus[i].valid           = 1'b1;
                issue_bus[i].pc              = buf_slot[i].pc;
                issue_bus[i].inst            = buf_slot[i].inst;
                issue_bus[i].src1_ready      = buf_slot[i].src1_ready;
                issue_bus[i].src2_ready      = buf_slot[i].src2_ready;
                issue_bus[i].phy_src1        = buf_slot[i].phy_src1;
                issue_bus[i].phy_src2        = buf_slot[i].phy_src2;
                issue_bus[i].phy_dest        = buf_slot[i].phy_dest;
                issue_bus[i].rob_entry_num   = rob_idx[i];
                issue_bus[i].store_num       = store_num[i];
                issue_bus[i].pre_store       = pre_store[i];
                issue_bus[i].pre_store_ready = pre_store_ready[i];
                issue_bus[i].is_store_op     = buf_slot[i].is_store_op;
                issue_bus[i].br_taken        = buf_slot[i].br_taken;
                issue_bus[i].bpu_entry       = buf_slot[i].bpu_entry;
                rob_bus[i].state             = Inst_Wait;
                rob_bus[i].pc                = buf_slot[i].pc;
                rob_bus[i].dest              = buf_slot[i].inst.rf_we ? buf_slot[i].inst.dest : '0;
                rob_bus[i].phy_dest          = buf_slot[i].phy_dest;
                rob_bus[i].old_dest          = buf_slot[i].old_dest;
                rob_bus[i].is_store_op       = buf_slot[i].is_store_op;
                rob_bus[i].exception         = 1'b0;
                rob_bus[i].verify_result     = 1'b0;
            end else begin
                issue_bus[i] = '0;
                rob_bus[i]   = '0;
            end
        end
    end

endmodule

// File: tb/tb_dispatch_queue_n.sv
// Self-checking bench for dispatch_queue_n: directed scenarios plus randomized traffic,
// all compared against a queue-based reference model.
module tb_dispatch_queue_n;
    import dispatch_queue_n_pkg::*;

    localparam int W = 2;

    logic                 clk;
    logic                 resetn;
    logic                 flush;
    logic                 stall;
    logic                 in_valid;
    logic                 in_ready;
    dispatch_slot_t       in_slot [W];
    logic [3:0]           rob_tail;
    logic [4:0]           rob_free;
    logic [3:0]           sq_tail;
    logic [4:0]           sq_free;
    logic [3:0]           iq_free;
    decode_to_issue_bus_t issue_bus [W];
    rob_entry_t           rob_bus [W];
    logic [1:0]           disp_cnt;
    logic [1:0]           store_cnt;

    int checks = 0;
    int errors = 0;

    dispatch_slot_t mq[$];
    int             exp_k;
    logic           exp_ready;
    dispatch_slot_t held;

    dispatch_queue_n #(.WIDTH(W), .ROB_AW(4), .SQ_AW(4), .IQ_CREDIT_W(4)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (flush),
        .stall     (stall),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_slot   (in_slot),
        .rob_tail  (rob_tail),
        .rob_free  (rob_free),
        .sq_tail   (sq_tail),
        .sq_free   (sq_free),
        .iq_free   (iq_free),
        .issue_bus (issue_bus),
        .rob_bus   (rob_bus),
        .disp_cnt  (disp_cnt),
        .store_cnt (store_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic dispatch_slot_t mk_slot(input logic valid, input logic store);
        dispatch_slot_t s;
        s.valid        = valid;
        s.pc           = $urandom();
        s.inst.rf_we   = 1'($urandom_range(0, 1));
        s.inst.dest    = 5'($urandom());
        s.inst.opcode  = 8'($urandom());
        s.inst.imm     = 16'($urandom());
        s.src1_ready   = 1'($urandom_range(0, 1));
        s.src2_ready   = 1'($urandom_range(0, 1));
        s.phy_src1     = 6'($urandom());
        s.phy_src2     = 6'($urandom());
        s.phy_dest     = 6'($urandom());
        s.old_dest     = 6'($urandom());
        s.is_store_op  = store;
        s.br_taken     = 1'($urandom_range(0, 1));
        s.bpu_entry    = 4'($urandom());
        return s;
    endfunction

    function automatic int stores_before(input int n);
        int c = 0;
        for (int i = 0; i < n; i++) c += int'(mq[i].is_store_op);
        return c;
    endfunction

    task automatic set_defaults();
        flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
        rob_tail = 4'd0; rob_free = 5'd16; sq_tail = 4'd0; sq_free = 5'd16; iq_free = 4'd15;
        for (int i = 0; i < W; i++) in_slot[i] = '0;
    endtask

    // Let the inputs settle, compute what the model expects and compare every output.
    task automatic settle_and_check();
        decode_to_issue_bus_t e;
        rob_entry_t           r;
        int                   s;
        #1;
        exp_k = 0;
        if (resetn && !flush && !stall) begin
            for (int n = mq.size(); n >= 0; n--) begin
                if (n <= int'(rob_free) && n <= int'(iq_free) && stores_before(n) <= int'(sq_free)) begin
                    exp_k = n;
                    break;
                end
            end
        end
        exp_ready = resetn && !flush && (mq.size() == 0 || exp_k == mq.size());
        s = 0;
        for (int i = 0; i < W; i++) begin
            e = '0;
            r = '0;
            if (i < exp_k) begin
                e.valid = 1'b1; e.pc = mq[i].pc; e.inst = mq[i].inst;
                e.src1_ready = mq[i].src1_ready; e.src2_ready = mq[i].src2_ready;
                e.phy_src1 = mq[i].phy_src1; e.phy_src2 = mq[i].phy_src2; e.phy_dest = mq[i].phy_dest;
                e.rob_entry_num = 4'((int'(rob_tail) + i) % 16);
                e.store_num = 4'((int'(sq_tail) + s) % 16);
                e.pre_store = 4'((int'(sq_tail) + s + 15) % 16);
                e.pre_store_ready = (sq_free == 5'd16) && (s == 0);
                e.is_store_op = mq[i].is_store_op; e.br_taken = mq[i].br_taken; e.bpu_entry = mq[i].bpu_entry;
                r.state = Inst_Wait; r.pc = mq[i].pc;
                r.dest = mq[i].inst.rf_we ? mq[i].inst.dest : 5'd0;
                r.phy_dest = mq[i].phy_dest; r.old_dest = mq[i].old_dest; r.is_store_op = mq[i].is_store_op;
                s += int'(mq[i].is_store_op);
            end
            check_val($sformatf("issue%0d", i), 256'(issue_bus[i]), 256'(e));
            check_val($sformatf("rob%0d", i), 256'(rob_bus[i]), 256'(r));
        end
        check_val("in_ready", 256'(in_ready), 256'(exp_ready));
        check_val("disp_cnt", 256'(disp_cnt), 256'(exp_k));
        check_val("store_cnt", 256'(store_cnt), 256'(s));
    endtask

    // Apply the model's next state, then move to the next falling edge.
    task automatic advance();
        if (!resetn || flush) begin
            mq.delete();
        end else if (in_valid && exp_ready) begin
            mq.delete();
            for (int i = 0; i < W; i++) if (in_slot[i].valid) mq.push_back(in_slot[i]);
        end else begin
            repeat (exp_k) void'(mq.pop_front());
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cyc();
        settle_and_check();
        advance();
    endtask

    initial begin
        set_defaults();
        resetn = 1'b0;
        @(negedge clk);
        cyc();
        cyc();
        check_val("rst_ready", 256'(in_ready), 256'(0));
        resetn = 1'b1;

        // Hole in lane 0: the valid slot lands on lane 0 one cycle later.
        in_slot[0] = mk_slot(1'b0, 1'b0);
        in_slot[1] = mk_slot(1'b1, 1'b0);
        held = in_slot[1];
        in_valid = 1'b1;
        cyc();
        set_defaults();
        rob_tail = 4'd5;
        settle_and_check();
        check_val("hole_cnt", 256'(disp_cnt), 256'(1));
        check_val("hole_pc", 256'(issue_bus[0].pc), 256'(held.pc));
        check_val("hole_rob", 256'(issue_bus[0].rob_entry_num), 256'(5));
        check_val("hole_lane1", 256'(issue_bus[1]), 256'(0));
        advance();

        // Two stores into an empty store queue at tail 3.
        in_slot[0] = mk_slot(1'b1, 1'b1);
        in_slot[1] = mk_slot(1'b1, 1'b1);
        in_valid = 1'b1;
        cyc();
        set_defaults();
        sq_tail = 4'd3;
        settle_and_check();
        check_val("st_num0", 256'(issue_bus[0].store_num), 256'(3));
        check_val("st_num1", 256'(issue_bus[1].store_num), 256'(4));
        check_val("st_pre0", 256'(issue_bus[0].pre_store), 256'(2));
        check_val("st_pre1", 256'(issue_bus[1].pre_store), 256'(3));
        check_val("st_rdy0", 256'(issue_bus[0].pre_store_ready), 256'(1));
        check_val("st_rdy1", 256'(issue_bus[1].pre_store_ready), 256'(0));
        check_val("st_cnt", 256'(store_cnt), 256'(2));
        advance();

        // Partial dispatch on a one-entry ROB, remainder goes next cycle with a new tail.
        in_slot[0] = mk_slot(1'b1, 1'b0);
        in_slot[1] = mk_slot(1'b1, 1'b0);
        held = in_slot[1];
        in_valid = 1'b1;
        cyc();
        set_defaults();
        rob_free = 5'd1;
        settle_and_check();
        check_val("part_k", 256'(disp_cnt), 256'(1));
        check_val("part_rdy", 256'(in_ready), 256'(0));
        advance();
        rob_free = 5'd4; rob_tail = 4'd9;
        settle_and_check();
        check_val("rem_pc", 256'(issue_bus[0].pc), 256'(held.pc));
        check_val("rem_rob", 256'(issue_bus[0].rob_entry_num), 256'(9));
        check_val("rem_rdy", 256'(in_ready), 256'(1));
        advance();

        // ROB index wraps past 15.
        in_slot[0] = mk_slot(1'b1, 1'b0);
        in_slot[1] = mk_slot(1'b1, 1'b0);
        in_valid = 1'b1;
        cyc();
        set_defaults();
        rob_tail = 4'd15;
        settle_and_check();
        check_val("wrap0", 256'(issue_bus[0].rob_entry_num), 256'(15));
        check_val("wrap1", 256'(issue_bus[1].rob_entry_num), 256'(0));
        advance();

        // Flush while a remainder is held; the concurrent group is dropped.
        in_slot[0] = mk_slot(1'b1, 1'b0);
        in_slot[1] = mk_slot(1'b1, 1'b0);
        in_valid = 1'b1;
        cyc();
        set_defaults();
        rob_free = 5'd1;
        cyc();
        flush = 1'b1; in_valid = 1'b1;
        in_slot[0] = mk_slot(1'b1, 1'b0);
        in_slot[1] = mk_slot(1'b1, 1'b0);
        settle_and_check();
        check_val("fl_cnt", 256'(disp_cnt), 256'(0));
        check_val("fl_bus0", 256'(issue_bus[0]), 256'(0));
        check_val("fl_rdy", 256'(in_ready), 256'(0));
        advance();
        set_defaults();
        settle_and_check();
        check_val("fl_after", 256'(disp_cnt), 256'(0));
        advance();

        // Back-to-back full groups, then reset mid-stream.
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_slot[0] = mk_slot(1'b1, 1'($urandom_range(0, 1)));
            in_slot[1] = mk_slot(1'b1, 1'($urandom_range(0, 1)));
            settle_and_check();
            check_val("b2b_rdy", 256'(in_ready), 256'(1));
            if (c > 0) check_val("b2b_cnt", 256'(disp_cnt), 256'(2));
            advance();
        end
        resetn = 1'b0;
        settle_and_check();
        check_val("rst_cnt", 256'(disp_cnt), 256'(0));
        check_val("rst_rdy", 256'(in_ready), 256'(0));
        advance();
        resetn = 1'b1;
        in_valid = 1'b0;
        settle_and_check();
        check_val("rel_cnt", 256'(disp_cnt), 256'(0));
        advance();

        // Randomized traffic.
        for (int c = 0; c < 600; c++) begin
            resetn   = ($urandom_range(0, 63) != 0);
            flush    = ($urandom_range(0, 15) == 0);
            stall    = ($urandom_range(0, 7) == 0);
            in_valid = ($urandom_range(0, 2) != 0);
            for (int i = 0; i < W; i++)
                in_slot[i] = mk_slot(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0));
            rob_tail = 4'($urandom());
            sq_tail  = 4'($urandom());
            rob_free = 5'($urandom_range(0, 16));
            sq_free  = 5'($urandom_range(0, 16));
            iq_free  = 4'($urandom_range(0, 15));
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
